mapred_job_ctrl: RTL and testbench
==================================

# mapred_job_ctrl

Job controller for the map-reduce user-logic path. Accepts a start command and a word count, distributes the upstream 32-bit stream round-robin across NUM_MAPPERS mappers, and waits a fixed drain time for the mapper pipelines. It then sequentially sums the per-mapper counts into a single result and presents that result on a valid/ready handshake. It sits between the host stream interface and the mapper array, and replaces free-running reduction with a sequenced, job-bounded one.

## Interface
- NUM_MAPPERS, 4: number of mappers; 2..1024.
- MAP_LATENCY, 2: drain cycles after the last dispatched word before counts are sampled; ≥1.
- i_clk  in  1  clock; all logic on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_start  in  1  job start pulse; sampled only in IDLE.
- i_job_len  in  32  number of words in the job; sampled with i_start.
- o_busy  out  1  high in every state except IDLE.
- i_data  in  32  upstream word.
- i_data_valid  in  1  upstream valid.
- o_data_ready  out  1  upstream ready.
- o_map_data  out  32  word broadcast to all mappers (equals i_data).
- o_map_valid  out  NUM_MAPPERS  one-hot valid to the selected mapper.
- i_map_ready  in  NUM_MAPPERS  per-mapper ready.
- o_map_clear  out  1  one-cycle pulse that clears all mapper counters.
- i_map_count  in  NUM_MAPPERS*32  mapper k count at bits [k*32 +: 32].
- o_result  out  32  reduced count.
- o_result_valid  out  1  result valid.
- i_result_ready  in  1  result accept.
- o_done  out  1  one-cycle pulse on the result handshake.

## Operation
- States: IDLE → CLEAR → DISPATCH → DRAIN → REDUCE → RESULT → IDLE.
- IDLE: i_start=1 latches i_job_len into `remaining` and moves to CLEAR. i_start is ignored in all other states.
- CLEAR: one cycle with o_map_clear=1. rr_ptr←0 and acc←0. Next state is DISPATCH if remaining≠0, otherwise DRAIN.
- DISPATCH:
  - o_data_ready = i_map_ready[rr_ptr].
  - o_map_valid = i_data_valid in bit rr_ptr, 0 elsewhere.
  - A transfer occurs when i_data_valid & o_data_ready. On a transfer, remaining decrements and rr_ptr increments, wrapping from NUM_MAPPERS-1 to 0.
  - The transfer that brings remaining to 0 moves the block to DRAIN.
  - Stalls (valid low or selected mapper not ready) hold rr_ptr. The word is never redirected to another mapper.
- DRAIN: count exactly MAP_LATENCY cycles, then go to REDUCE with idx←0.
- REDUCE: one mapper per cycle, acc←acc+i_map_count[idx*32 +: 32], for idx=0..NUM_MAPPERS-1 (never idx=NUM_MAPPERS). After the last add, go to RESULT.
- RESULT:
  - o_result=acc and o_result_valid=1. Both are held stable until i_result_ready.
  - The handshake cycle pulses o_done and returns to IDLE.
  - A new i_start in that same cycle is ignored and must be re-issued in IDLE.
- Arithmetic: sum is modulo 2^32; carries are discarded (see Configuration).
- o_data_ready=0 and o_map_valid=0 outside DISPATCH.
- Reset values: o_busy=0, o_data_ready=0, o_map_valid=0, o_map_clear=0, o_result=0, o_result_valid=0, o_done=0. State is IDLE and all counters are 0.
- Reset mid-job: returns to IDLE next cycle, with no clear pulse and no result.

## Timing
- For i_start sampled at cycle T with always-valid data and ready mappers:
  - CLEAR at T+1.
  - DISPATCH at T+2..T+1+L.
  - DRAIN for MAP_LATENCY cycles.
  - REDUCE for NUM_MAPPERS cycles.
  - o_result_valid first high at T+2+L+MAP_LATENCY+NUM_MAPPERS.
- L=0 follows the same formula: no DISPATCH cycles, and the result equals the sum of the mapper counts after the clear.
- Throughput in DISPATCH is 1 word/cycle at most.
- Every output is registered except o_data_ready, o_map_valid and o_map_data. These are combinational from rr_ptr/state and the upstream/mapper inputs.

## Configuration
- MAPRED_OVERFLOW_EN defined:
  - Adds output o_overflow (1 bit).
  - o_overflow is cleared in CLEAR and set sticky if any REDUCE addition carries out of bit 31.
  - It is valid alongside o_result_valid and resets to 0.
- Undefined: no o_overflow port and no carry logic; wrap is silent.

## Test plan
- NUM_MAPPERS=4, MAP_LATENCY=2, L=8, all ready, mapper model counts its words:
  - o_map_valid sequence is 1,2,4,8,1,2,4,8.
  - o_result=8, o_result_valid first at T+16.
- L=0 with counts pre-loaded 5,6,7,8: o_map_clear pulse at T+1, then the models clear, so o_result=0 at T+8.
- Backpressure:
  - i_map_ready[1]=0 for 3 cycles while rr_ptr=1: o_data_ready=0, rr_ptr holds, no word goes to mapper 2.
  - Final result is unchanged (8).
- Counts 0xFFFF_FFFF,1,0,0 forced:
  - o_result=0.
  - With MAPRED_OVERFLOW_EN, o_overflow=1; without it, no such port.
- i_result_ready held low 10 cycles: o_result stable and valid; o_done pulses exactly once on accept; i_start during RESULT is ignored.
- i_rst asserted mid-DISPATCH (after 3 of 8 words):
  - Next cycle all outputs are 0 and o_busy=0.
  - A new job of L=4 completes normally with o_result=4.

Source files
------------

// File: rtl/mapred_job_ctrl_if.sv
// Bundle of job, upstream, mapper and result signals for mapred_job_ctrl.
// Optional macro MAPRED_OVERFLOW_EN adds the o_overflow status bit.
//
// Handshake rule for every valid/ready pair here: a word or result moves
// on a rising edge where valid and ready are both high. A source that
// raises valid holds its data stable until that edge. Ready may depend
// combinationally on the state of the sink but never on valid.
interface mapred_job_ctrl_if #(
    parameter int NUM_MAPPERS = 4
);
    logic                      i_start;
    logic [31:0]               i_job_len;
    logic                      o_busy;
    logic [31:0]               i_data;
    logic                      i_data_valid;
    logic                      o_data_ready;
    logic [31:0]               o_map_data;
    logic [NUM_MAPPERS-1:0]    o_map_valid;
    logic [NUM_MAPPERS-1:0]    i_map_ready;
    logic                      o_map_clear;
    logic [NUM_MAPPERS*32-1:0] i_map_count;
    logic [31:0]               o_result;
    logic                      o_result_valid;
    logic                      i_result_ready;
    logic                      o_done;
    logic [2:0]                o_state;
`ifdef MAPRED_OVERFLOW_EN
    logic                      o_overflow;
`endif

    modport slave (
        input  i_start, i_job_len, i_data, i_data_valid, i_map_ready,
               i_map_count, i_result_ready,
        output o_busy, o_data_ready, o_map_data, o_map_valid, o_map_clear,
               o_result, o_result_valid, o_done, o_state
`ifdef MAPRED_OVERFLOW_EN
        , output o_overflow
`endif
    );

    modport master (
        output i_start, i_job_len, i_data, i_data_valid, i_map_ready,
               i_map_count, i_result_ready,
        input  o_busy, o_data_ready, o_map_data, o_map_valid, o_map_clear,
               o_result, o_result_valid, o_done, o_state
`ifdef MAPRED_OVERFLOW_EN
        , input o_overflow
`endif
    );
endinterface

// File: rtl/mapred_job_ctrl.sv
// Map-reduce job controller: clears the mappers, deals a job of words
// round-robin across them, waits for their pipelines to drain, then sums
// the per-mapper counts one per cycle and offers the total on a
// valid/ready result port.
// Optional macro MAPRED_OVERFLOW_EN adds a sticky carry-out flag.
module mapred_job_ctrl #(
    parameter int NUM_MAPPERS = 4,
    parameter int MAP_LATENCY = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    mapred_job_ctrl_if.slave  bus
);
    localparam int PTR_W = (NUM_MAPPERS > 1) ? $clog2(NUM_MAPPERS) : 1;
    localparam logic [PTR_W-1:0] LAST_IDX   = PTR_W'(NUM_MAPPERS - 1);
    localparam logic [31:0]      DRAIN_LAST = 32'(MAP_LATENCY - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CLEAR    = 3'd1,
        S_DISPATCH = 3'd2,
        S_DRAIN    = 3'd3,
        S_REDUCE   = 3'd4,
        S_RESULT   = 3'd5
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [31:0]            remaining;
    logic [PTR_W-1:0]       rr_ptr;
    logic [PTR_W-1:0]       idx;
    logic [31:0]            drain_cnt;
    logic [31:0]            acc;
    logic [31:0]            count_sel;
    logic [31:0]            sum;
    logic [NUM_MAPPERS-1:0] map_valid_c;
    logic                   data_ready_c;
    logic                   xfer;
`ifdef MAPRED_OVERFLOW_EN
    logic                   carry;
    logic                   ovf;
`endif

    // Upstream/mapper steering and the reduction adder (combinational).
    always_comb begin
        map_valid_c  = '0;
        data_ready_c = 1'b0;
        if (state == S_DISPATCH) begin
            data_ready_c        = bus.i_map_ready[rr_ptr];
            map_valid_c[rr_ptr] = bus.i_data_valid;
        end
        xfer      = data_ready_c & bus.i_data_valid;
        count_sel = bus.i_map_count[{idx, 5'b0} +: 32];
`ifdef MAPRED_OVERFLOW_EN
        {carry, sum} = {1'b0, acc} + {1'b0, count_sel};
`else
        sum = acc + count_sel;
`endif
    end

    assign bus.o_data_ready = data_ready_c;
    assign bus.o_map_valid  = map_valid_c;
    assign bus.o_map_data   = bus.i_data;
    assign bus.o_state      = state;
`ifdef MAPRED_OVERFLOW_EN
    assign bus.o_overflow   = ovf;
`endif

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) state <= S_IDLE;
        else       state <= state_next;
    end

    // Next-state decode for the job sequence.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:     if (bus.i_start) state_next = S_CLEAR;
            S_CLEAR:    state_next = (remaining != 32'd0) ? S_DISPATCH : S_DRAIN;
            S_DISPATCH: if (xfer && remaining == 32'd1) state_next = S_DRAIN;
            S_DRAIN:    if (drain_cnt == DRAIN_LAST) state_next = S_REDUCE;
            S_REDUCE:   if (idx == LAST_IDX) state_next = S_RESULT;
            S_RESULT:   if (bus.i_result_ready) state_next = S_IDLE;
            default:    state_next = S_IDLE;
        endcase
    end

    // Job counters, accumulator and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            remaining          <= '0;
            rr_ptr             <= '0;
            idx                <= '0;
            drain_cnt          <= '0;
            acc                <= '0;
            bus.o_busy         <= 1'b0;
            bus.o_map_clear    <= 1'b0;
            bus.o_result       <= '0;
            bus.o_result_valid <= 1'b0;
            bus.o_done         <= 1'b0;
`ifdef MAPRED_OVERFLOW_EN
            ovf                <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.i_start) remaining <= bus.i_job_len;
                end
                S_CLEAR: begin
                    rr_ptr    <= '0;
                    acc       <= '0;
                    drain_cnt <= '0;
`ifdef MAPRED_OVERFLOW_EN
                    ovf       <= 1'b0;
`endif
                end
                S_DISPATCH: begin
                    if (xfer) begin
                        remaining <= remaining - 32'd1;
                        rr_ptr    <= (rr_ptr == LAST_IDX) ? '0 : rr_ptr + 1'b1;
                    end
                end
                S_DRAIN: begin
                    drain_cnt <= (drain_cnt == DRAIN_LAST) ? 32'd0 : drain_cnt + 32'd1;
                    idx       <= '0;
                end
                S_REDUCE: begin
                    acc <= sum;
                    idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
`ifdef MAPRED_OVERFLOW_EN
                    if (carry) ovf <= 1'b1;
`endif
                end
                default: ;
            endcase

            // Outputs are registered against the state being entered so
            // they line up with that state's cycle.
            bus.o_busy         <= (state_next != S_IDLE);
            bus.o_map_clear    <= (state_next == S_CLEAR);
            bus.o_result_valid <= (state_next == S_RESULT);
            if (state_next == S_RESULT)
                bus.o_result <= (state == S_REDUCE) ? sum : acc;
            else
                bus.o_result <= '0;
            bus.o_done <= (state == S_RESULT) && bus.i_result_ready;
        end
    end
endmodule

// File: tb/tb_mapred_job_ctrl.sv
// Testbench for mapred_job_ctrl with NUM_MAPPERS=4, MAP_LATENCY=2.
// Mapper models count their accepted words; a monitor compares every
// dispatched word and every result against scoreboard queues.
module tb_mapred_job_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mapred_job_ctrl_if #(.NUM_MAPPERS(4)) bus();

    mapred_job_ctrl #(.NUM_MAPPERS(4), .MAP_LATENCY(2)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          t0 = 0;
    int          done_cnt = 0;
    logic [31:0] exp_q[$];
    int          lat_q[$];
    logic        exp_ovf_q[$];
    logic [35:0] map_q[$];
    logic [31:0] dcount = 32'h1000_0000;
    logic [31:0] cnt[4];
    logic [31:0] load_vals[4];
    logic [31:0] force_vals[4];
    logic        load_req = 1'b0;
    logic        force_mode = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Cycle counter and upstream word source.
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (bus.i_data_valid && bus.o_data_ready) dcount <= dcount + 1;
    assign bus.i_data = dcount;

    // Mapper models: each counts the words it accepts.
    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (rst) cnt[k] <= '0;
            else if (bus.o_map_clear) cnt[k] <= '0;
            else if (load_req) cnt[k] <= load_vals[k];
            else if (bus.o_map_valid[k] && bus.i_map_ready[k]) cnt[k] <= cnt[k] + 1;
        end
    end

    always_comb begin
        bus.i_map_count = '0;
        for (int k = 0; k < 4; k++)
            bus.i_map_count[k*32 +: 32] = force_mode ? force_vals[k] : cnt[k];
    end

    // Monitor: sample just after the falling edge, pop and compare.
    logic        prev_valid = 1'b0;
    logic        done_due = 1'b0;
    logic [31:0] prev_result = '0;
    always @(negedge clk) begin
        #1;
        if (rst) begin
            prev_valid = 1'b0;
            done_due   = 1'b0;
        end else begin
            if (done_due) check("done_pulse", {63'd0, bus.o_done}, 64'd1);
            else if (bus.o_done) check("done_spurious", {63'd0, bus.o_done}, 64'd0);
            if (bus.o_done) done_cnt++;
            done_due = 1'b0;

            if (bus.i_data_valid && bus.o_data_ready) begin
                if (map_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL map_unexpected: got 0x%0h, expected no transfer",
                             {bus.o_map_data, bus.o_map_valid});
                end else begin
                    logic [35:0] e;
                    e = map_q.pop_front();
                    check("map_xfer", {28'd0, bus.o_map_data, bus.o_map_valid}, {28'd0, e});
                end
            end

            if (bus.o_result_valid && !prev_valid && lat_q.size() != 0) begin
                int lat;
                lat = lat_q.pop_front();
                if (lat >= 0) check("result_latency", 64'(cyc - t0), 64'(lat));
            end
            if (bus.o_result_valid && prev_valid)
                check("result_stable", {32'd0, bus.o_result}, {32'd0, prev_result});

            if (bus.o_result_valid && bus.i_result_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL result_unexpected: got 0x%0h, expected none", bus.o_result);
                end else begin
                    logic [31:0] er;
                    logic        eo;
                    er = exp_q.pop_front();
                    eo = exp_ovf_q.pop_front();
                    check("result_value", {32'd0, bus.o_result}, {32'd0, er});
`ifdef MAPRED_OVERFLOW_EN
                    check("overflow", {63'd0, bus.o_overflow}, {63'd0, eo});
`endif
                    done_due = (eo == eo);
                end
            end
            prev_valid  = bus.o_result_valid;
            prev_result = bus.o_result;
        end
    end

    // Issue a start pulse and push the expected word stream and result.
    task automatic start_job(input logic [31:0] len, input logic [31:0] res,
                             input int lat, input logic ovf);
        @(negedge clk);
        bus.i_start   = 1'b1;
        bus.i_job_len = len;
        t0 = cyc;
        for (int j = 0; j < int'(len); j++)
            map_q.push_back({dcount + 32'(j), 4'(1 << (j % 4))});
        exp_q.push_back(res);
        lat_q.push_back(lat);
        exp_ovf_q.push_back(ovf);
        @(negedge clk);
        bus.i_start = 1'b0;
        check("clear_pulse", {63'd0, bus.o_map_clear}, 64'd1);
        check("busy_in_job", {63'd0, bus.o_busy}, 64'd1);
    endtask

    // Wait (bounded) for all expected results to be consumed.
    task automatic wait_results();
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("result_timeout", 64'(exp_q.size()), 64'd0);
        if (exp_q.size() != 0) begin
            exp_q.delete();
            lat_q.delete();
            exp_ovf_q.delete();
        end
        repeat (2) @(negedge clk);
        check("words_drained", 64'(map_q.size()), 64'd0);
        map_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] base;
        int          n;
        bus.i_start        = 1'b0;
        bus.i_job_len      = '0;
        bus.i_data_valid   = 1'b1;
        bus.i_map_ready    = 4'hF;
        bus.i_result_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            load_vals[k]  = '0;
            force_vals[k] = '0;
        end

        // Reset values.
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy",        {63'd0, bus.o_busy}, 64'd0);
        check("rst_data_ready",  {63'd0, bus.o_data_ready}, 64'd0);
        check("rst_map_valid",   {60'd0, bus.o_map_valid}, 64'd0);
        check("rst_map_clear",   {63'd0, bus.o_map_clear}, 64'd0);
        check("rst_result",      {32'd0, bus.o_result}, 64'd0);
        check("rst_result_valid",{63'd0, bus.o_result_valid}, 64'd0);
        check("rst_done",        {63'd0, bus.o_done}, 64'd0);
        check("rst_state",       {61'd0, bus.o_state}, 64'd0);
`ifdef MAPRED_OVERFLOW_EN
        check("rst_overflow",    {63'd0, bus.o_overflow}, 64'd0);
`endif
        rst = 1'b0;

        // Job 1: L=8, all ready; two words per mapper, valid at T+16.
        start_job(32'd8, 32'd8, 16, 1'b0);
        wait_results();

        // Job 2: L=0 with stale counts 5,6,7,8 that the clear must wipe.
        @(negedge clk);
        load_vals[0] = 32'd5; load_vals[1] = 32'd6;
        load_vals[2] = 32'd7; load_vals[3] = 32'd8;
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
        start_job(32'd0, 32'd0, 8, 1'b0);
        wait_results();

        // Job 3: mapper 1 stalls for 3 cycles; result still 8, valid at T+19.
        @(negedge clk);
        bus.i_map_ready = 4'b1101;
        start_job(32'd8, 32'd8, 19, 1'b0);
        n = 0;
        while (bus.o_map_valid != 4'b0010 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("stall_reached", {60'd0, bus.o_map_valid}, 64'h2);
        for (int i = 0; i < 3; i++) begin
            check("stall_ready", {63'd0, bus.o_data_ready}, 64'd0);
            check("stall_hold",  {60'd0, bus.o_map_valid}, 64'h2);
            @(negedge clk);
        end
        bus.i_map_ready = 4'hF;
        wait_results();

        // Job 4: forced counts wrap to 0 with a carry out.
        force_vals[0] = 32'hFFFF_FFFF; force_vals[1] = 32'd1;
        force_vals[2] = 32'd0;         force_vals[3] = 32'd0;
        force_mode = 1'b1;
        start_job(32'd0, 32'd0, 8, 1'b1);
        wait_results();
        force_mode = 1'b0;

        // Job 5: result held 10 cycles; starts during RESULT are ignored.
        bus.i_result_ready = 1'b0;
        start_job(32'd4, 32'd4, 12, 1'b0);
        n = 0;
        while (!bus.o_result_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("hold_reached", {63'd0, bus.o_result_valid}, 64'd1);
        for (int i = 0; i < 10; i++) begin
            bus.i_start   = (i == 5);
            bus.i_job_len = 32'd5;
            @(negedge clk);
        end
        check("hold_valid",  {63'd0, bus.o_result_valid}, 64'd1);
        check("hold_result", {32'd0, bus.o_result}, 64'd4);
        bus.i_result_ready = 1'b1;
        bus.i_start        = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        @(negedge clk);
        check("ignored_start_busy", {63'd0, bus.o_busy}, 64'd0);
        @(negedge clk);
        check("ignored_start_busy2", {63'd0, bus.o_busy}, 64'd0);
        check("ignored_start_state", {61'd0, bus.o_state}, 64'd0);
        wait_results();

        // Job 6: reset after 3 of 8 words; nothing must come out.
        base = dcount;
        start_job(32'd8, 32'd0, -1, 1'b0);
        void'(exp_q.pop_back());
        void'(lat_q.pop_back());
        void'(exp_ovf_q.pop_back());
        n = 0;
        while (dcount != base + 32'd3 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("abort_words", {32'd0, dcount - base}, 64'd3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        map_q.delete();
        check("abort_busy",         {63'd0, bus.o_busy}, 64'd0);
        check("abort_data_ready",   {63'd0, bus.o_data_ready}, 64'd0);
        check("abort_map_valid",    {60'd0, bus.o_map_valid}, 64'd0);
        check("abort_map_clear",    {63'd0, bus.o_map_clear}, 64'd0);
        check("abort_result_valid", {63'd0, bus.o_result_valid}, 64'd0);
        check("abort_result",       {32'd0, bus.o_result}, 64'd0);
        check("abort_done",         {63'd0, bus.o_done}, 64'd0);
        check("abort_state",        {61'd0, bus.o_state}, 64'd0);

        // Job 7: fresh L=4 job after the abort.
        start_job(32'd4, 32'd4, 12, 1'b0);
        wait_results();

        check("done_count", 64'(done_cnt), 64'd6);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
